addr_seq_tr: RTL and testbench
==============================

# addr_seq_tr

Parametrised, multi-cycle unsigned adder that succeeds the fixed 4-bit combinational adder netlists in this library. It computes A+B in CHUNK-bit slices, one slice per clock, with a rippling carry register. An optional time-redundant second pass recomputes the sum with operands swapped (B+A) and flags any mismatch, giving fault detection at the cost of latency. It sits behind a valid/ready operand interface and drives a valid/ready result interface.

## Interface
- WIDTH, 16: operand width in bits. Must be ≥1.
- CHUNK, 4: slice width added per cycle. WIDTH % CHUNK == 0 is required. N = WIDTH/CHUNK.
- ERRW, 8: width of the saturating error counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  high iff state==IDLE and rst==0.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- tr_en  in  1  time-redundant mode for this operation; captured at acceptance.
- fi_en  in  1  test hook, captured at acceptance. When set, inverts bit 0 of the pass-1 slice-0 sum.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed.
- sum  out  WIDTH+1  A+B; MSB is the carry-out.
- err  out  1  pass-1/pass-2 mismatch for this result. Always 0 when tr_en was 0.
- err_cnt  out  ERRW  saturating count of results with err=1 since reset.

## Operation
- States: IDLE, PASS1, PASS2, DONE. A 2-bit encoding is sufficient.
- IDLE:
  - An accept happens when in_valid && in_ready.
  - On accept, register a, b, tr_en and fi_en; clear the carry register and slice index k; go to PASS1.
- PASS1, each edge:
  - {c, s} = a[k*CHUNK +: CHUNK] + b[k*CHUNK +: CHUNK] + c.
  - Store s into r1[k*CHUNK +: CHUNK]; increment k.
  - If fi_en && k==0, store s^1 instead.
  - On the edge where k==N-1:
    - store the final carry into r1[WIDTH];
    - if tr_en, clear c and k and go to PASS2;
    - otherwise load sum<=r1 (including this slice) and err<=0, then go to DONE.
- PASS2:
  - Same slice arithmetic with operand roles swapped (b slice + a slice + c), written into r2.
  - On the edge where k==N-1:
    - sum<=r2 (including final slice and carry);
    - err<=(r1 != r2 final);
    - if err and err_cnt is not all-ones, increment err_cnt;
    - go to DONE.
- DONE:
  - out_valid=1; sum and err are held stable.
  - On out_valid && out_ready, go to IDLE.
  - No operand is accepted in the same cycle: in_ready is 0 in DONE.
- On an error, sum reports the pass-2 value.
- err_cnt saturates at 2^ERRW-1 and never wraps.
- Width rules:
  - All arithmetic is unsigned and modulo-free.
  - sum carries the full WIDTH+1 result, so no overflow is possible.
  - The slice adder is CHUNK+1 bits wide.
- Reset (any state, including mid-pass or in DONE with out_ready low):
  - state=IDLE, out_valid=0, sum=0, err=0, err_cnt=0;
  - c, k, r1, r2 cleared;
  - the in-flight operation is dropped and produces no result.
  - in_ready=0 while rst=1 and 1 on the first cycle after.
- Inputs a, b, tr_en and fi_en are ignored outside the accept cycle, so they may change freely mid-operation.

## Timing
- Accept at edge E. With tr_en=0, out_valid is high from edge E+N onward. With tr_en=1, it is high from edge E+2N onward.
- N=1 is legal: PASS1 lasts one edge.
- Result handshake completes at the first edge with out_valid && out_ready. out_valid is low and in_ready is high after that edge.
- Back-to-back throughput: one result per N+2 cycles (2N+2 with tr_en). This counts the accept cycle in IDLE and the handshake cycle in DONE, with out_ready tied high.
- Outputs are fully registered; in_ready and out_valid are decoded from the state register only.

## Test plan
- WIDTH=16, CHUNK=4, tr_en=0: a=0xFFFF, b=0x0001 → sum=0x10000, err=0, out_valid rises 4 edges after accept.
- tr_en=1: a=0x1234, b=0x4321 → sum=0x05555, err=0, err_cnt=0, out_valid rises 8 edges after accept.
- tr_en=1, fi_en=1: a=0x0000, b=0x0000 → sum=0x00000, err=1, err_cnt=1. Repeat with tr_en=0, fi_en=1 → sum=0x00001, err=0, err_cnt unchanged.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum, err and out_valid stable, in_ready=0, new in_valid ignored. Release → single handshake, then IDLE.
- Reset mid-PASS1 (after 2 slices) → next cycle out_valid=0, sum=0, in_ready=1. A subsequent accept of a=0x00FF, b=0x0001 yields sum=0x00100.
- ERRW=2: six tr_en=1, fi_en=1 operations → err_cnt reads 1, 2, 3, 3, 3, 3.

Source files
------------

// File: rtl/addr_seq_tr.sv
`default_nettype none
// ============================================================================
// Module      : addr_seq_tr
// Description : Multi-cycle unsigned adder. Adds A+B one CHUNK-bit slice per
//               clock with a rippling carry register. An optional
//               time-redundant second pass recomputes the sum with operands
//               swapped and flags any pass-1/pass-2 mismatch.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               in_valid/in_ready  - operand handshake (a, b, tr_en, fi_en)
//               out_valid/out_ready- result handshake (sum, err)
//               sum                - WIDTH+1 bit result, MSB is carry-out
//               err                - mismatch flag for the current result
//               err_cnt            - saturating count of erroneous results
// Revision    : 1.0 - initial release
// ============================================================================
module addr_seq_tr #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             tr_en,
    input  logic             fi_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             err,
    output logic [ERRW-1:0]  err_cnt
);

    localparam int c_n  = WIDTH / CHUNK;
    localparam int c_kw = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [c_kw-1:0] c_k_last = c_kw'(c_n - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PASS1 = 2'd1;
    localparam logic [1:0] S_PASS2 = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_tr;
    logic             r_fi;
    logic             r_c;
    logic [c_kw-1:0]  r_k;
    logic [WIDTH:0]   r_r1;
    logic [WIDTH:0]   r_r2;
    logic [WIDTH:0]   r_sum;
    logic             r_err;
    logic [ERRW-1:0]  r_err_cnt;

    logic [CHUNK-1:0] w_sa;
    logic [CHUNK-1:0] w_sb;
    logic [CHUNK:0]   w_add;
    logic [CHUNK-1:0] w_s;
    logic             w_last;
    logic [WIDTH:0]   w_r1_nx;
    logic [WIDTH:0]   w_r2_nx;
    logic             w_mis;

    assign w_last = (r_k == c_k_last);

    // Slice datapath. Selects use constant indices under a compare on k so
    // every part-select is static.
    always_comb begin
        w_sa = '0;
        w_sb = '0;
        for (int i = 0; i < c_n; i++) begin
            if (r_k == c_kw'(i)) begin
                w_sa = r_a[i*CHUNK +: CHUNK];
                w_sb = r_b[i*CHUNK +: CHUNK];
            end
        end

        // Second pass swaps operand roles so a fault tied to one operand
        // path shows up differently in the two results.
        if (r_state == S_PASS2) begin
            w_add = {1'b0, w_sb} + {1'b0, w_sa} + {{CHUNK{1'b0}}, r_c};
        end else begin
            w_add = {1'b0, w_sa} + {1'b0, w_sb} + {{CHUNK{1'b0}}, r_c};
        end

        w_s = w_add[CHUNK-1:0];
        // Fault-injection hook: corrupt bit 0 of the first pass-1 slice.
        if ((r_state == S_PASS1) && r_fi && (r_k == '0)) begin
            w_s[0] = ~w_s[0];
        end

        // Next images of r1/r2 include the current slice so the final edge
        // can load the complete result straight into sum.
        w_r1_nx = r_r1;
        w_r2_nx = r_r2;
        for (int i = 0; i < c_n; i++) begin
            if (r_k == c_kw'(i)) begin
                w_r1_nx[i*CHUNK +: CHUNK] = w_s;
                w_r2_nx[i*CHUNK +: CHUNK] = w_s;
            end
        end
        if (w_last) begin
            w_r1_nx[WIDTH] = w_add[CHUNK];
            w_r2_nx[WIDTH] = w_add[CHUNK];
        end
    end

    assign w_mis = (r_r1 != w_r2_nx);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nx = S_PASS1;
                end
            end
            S_PASS1: begin
                if (w_last) begin
                    w_state_nx = r_tr ? S_PASS2 : S_DONE;
                end
            end
            S_PASS2: begin
                if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_tr      <= 1'b0;
            r_fi      <= 1'b0;
            r_c       <= 1'b0;
            r_k       <= '0;
            r_r1      <= '0;
            r_r2      <= '0;
            r_sum     <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a  <= a;
                        r_b  <= b;
                        r_tr <= tr_en;
                        r_fi <= fi_en;
                        r_c  <= 1'b0;
                        r_k  <= '0;
                    end
                end
                S_PASS1: begin
                    r_r1 <= w_r1_nx;
                    r_c  <= w_add[CHUNK];
                    r_k  <= r_k + 1'b1;
                    if (w_last) begin
                        r_c <= 1'b0;
                        r_k <= '0;
                        if (!r_tr) begin
                            r_sum <= w_r1_nx;
                            r_err <= 1'b0;
                        end
                    end
                end
                S_PASS2: begin
                    r_r2 <= w_r2_nx;
                    r_c  <= w_add[CHUNK];
                    r_k  <= r_k + 1'b1;
                    if (w_last) begin
                        r_c   <= 1'b0;
                        r_k   <= '0;
                        r_sum <= w_r2_nx;
                        r_err <= w_mis;
                        if (w_mis && (r_err_cnt != {ERRW{1'b1}})) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_addr_seq_tr.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_seq_tr
// Description : Directed self-checking bench for addr_seq_tr. Main instance
//               is 16/4/8; a second instance uses ERRW=2 for saturation and
//               a third uses CHUNK=WIDTH (single-slice passes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_seq_tr;

    logic        clk;
    logic        rst;
    int          n_vec;
    int          n_err;

    // main instance
    logic        in_valid, in_ready, tr_en, fi_en, out_valid, out_ready, err;
    logic [15:0] a, b;
    logic [16:0] sum;
    logic [7:0]  err_cnt;

    // ERRW=2 instance
    logic        in_valid2, in_ready2, tr_en2, fi_en2, out_valid2, out_ready2, err2;
    logic [15:0] a2, b2;
    logic [16:0] sum2;
    logic [1:0]  err_cnt2;

    // single-slice instance
    logic        in_valid3, in_ready3, tr_en3, fi_en3, out_valid3, out_ready3, err3;
    logic [7:0]  a3, b3;
    logic [8:0]  sum3;
    logic [7:0]  err_cnt3;

    addr_seq_tr #(.WIDTH(16), .CHUNK(4), .ERRW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .tr_en(tr_en), .fi_en(fi_en), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .err(err), .err_cnt(err_cnt)
    );

    addr_seq_tr #(.WIDTH(16), .CHUNK(4), .ERRW(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .tr_en(tr_en2), .fi_en(fi_en2), .out_valid(out_valid2),
        .out_ready(out_ready2), .sum(sum2), .err(err2), .err_cnt(err_cnt2)
    );

    addr_seq_tr #(.WIDTH(8), .CHUNK(8), .ERRW(8)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .a(a3), .b(b3), .tr_en(tr_en3), .fi_en(fi_en3), .out_valid(out_valid3),
        .out_ready(out_ready3), .sum(sum3), .err(err3), .err_cnt(err_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one operand to the main instance at a negedge, scramble the
    // inputs after the accept edge, and return how many edges after the
    // accept edge out_valid was first seen high (64 means timeout).
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_,
                          input logic ttr, input logic tfi, output int lat);
        @(negedge clk);
        a = ta; b = tb_; tr_en = ttr; fi_en = tfi; in_valid = 1'b1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        tr_en = 1'($urandom); fi_en = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || sum !== 17'h0 ||
            err !== 1'b0 || err_cnt !== 8'h0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b vld=%b sum=%h err=%b cnt=%h required 0 0 00000 0 00",
                     in_ready, out_valid, sum, err, err_cnt);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        n_vec++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL basic_latency: %0d edges required 4", lat);
        end
        n_vec++;
        if (sum !== 17'h10000 || err !== 1'b0) begin
            n_err++;
            $display("FAIL basic_sum: sum=%h err=%b required 10000 0", sum, err);
        end
        consume();
    endtask

    task automatic test_tr();
        int lat;
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, lat);
        n_vec++;
        if (lat !== 8) begin
            n_err++;
            $display("FAIL tr_latency: %0d edges required 8", lat);
        end
        n_vec++;
        if (sum !== 17'h05555 || err !== 1'b0 || err_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL tr_sum: sum=%h err=%b cnt=%0d required 05555 0 0", sum, err, err_cnt);
        end
        consume();
    endtask

    task automatic test_fault();
        int lat;
        run_op(16'h0000, 16'h0000, 1'b1, 1'b1, lat);
        n_vec++;
        if (lat !== 8 || sum !== 17'h00000 || err !== 1'b1 || err_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL fault_tr: lat=%0d sum=%h err=%b cnt=%0d required 8 00000 1 1",
                     lat, sum, err, err_cnt);
        end
        consume();
        run_op(16'h0000, 16'h0000, 1'b0, 1'b1, lat);
        n_vec++;
        if (lat !== 4 || sum !== 17'h00001 || err !== 1'b0 || err_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL fault_notr: lat=%0d sum=%h err=%b cnt=%0d required 4 00001 0 1",
                     lat, sum, err, err_cnt);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, lat);
        n_vec++;
        if (lat !== 4 || sum !== 17'h01000) begin
            n_err++;
            $display("FAIL bp_sum: lat=%0d sum=%h required 4 01000", lat, sum);
        end
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; tr_en = 1'b0; fi_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 17'h01000 || err !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b sum=%h err=%b required 1 0 01000 0",
                         i, out_valid, in_ready, sum, err);
            end
        end
        in_valid = 1'b0;
        consume();
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_single: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        a = 16'h1111; b = 16'h1111; tr_en = 1'b0; fi_en = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || sum !== 17'h0 || err_cnt !== 8'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid: vld=%b sum=%h cnt=%0d rdy=%b required 0 00000 0 1",
                     out_valid, sum, err_cnt, in_ready);
        end
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) lat++;
        end
        n_vec++;
        if (lat !== 0) begin
            n_err++;
            $display("FAIL rst_dropped: out_valid high %0d cycles required 0", lat);
        end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
        n_vec++;
        if (lat !== 4 || sum !== 17'h00100) begin
            n_err++;
            $display("FAIL rst_after: lat=%0d sum=%h required 4 00100", lat, sum);
        end
        consume();
    endtask

    task automatic test_err_sat();
        int lat;
        int exp_cnt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a2 = 16'(i * 16'h0111); b2 = 16'h0202; tr_en2 = 1'b1; fi_en2 = 1'b1; in_valid2 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid2 = 1'b0;
            lat = 0;
            while (out_valid2 !== 1'b1 && lat < 64) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            n_vec++;
            if (lat !== 8 || err2 !== 1'b1 || int'(err_cnt2) !== exp_cnt ||
                sum2 !== 17'(i * 16'h0111 + 16'h0202)) begin
                n_err++;
                $display("FAIL err_sat%0d: lat=%0d err=%b cnt=%0d sum=%h required 8 1 %0d %h",
                         i, lat, err2, err_cnt2, sum2, exp_cnt, 17'(i * 16'h0111 + 16'h0202));
            end
        end
    endtask

    task automatic test_single_slice();
        int lat;
        @(negedge clk);
        a3 = 8'hFF; b3 = 8'h01; tr_en3 = 1'b1; fi_en3 = 1'b0; in_valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid3 = 1'b0;
        lat = 0;
        while (out_valid3 !== 1'b1 && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_vec++;
        if (lat !== 2 || sum3 !== 9'h100 || err3 !== 1'b0) begin
            n_err++;
            $display("FAIL n1_tr: lat=%0d sum=%h err=%b required 2 100 0", lat, sum3, err3);
        end
        @(negedge clk);
        a3 = 8'h10; b3 = 8'h20; tr_en3 = 1'b0; fi_en3 = 1'b1; in_valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid3 = 1'b0;
        lat = 0;
        while (out_valid3 !== 1'b1 && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_vec++;
        if (lat !== 1 || sum3 !== 9'h031 || err3 !== 1'b0 || err_cnt3 !== 8'd0) begin
            n_err++;
            $display("FAIL n1_fi: lat=%0d sum=%h err=%b cnt=%0d required 1 031 0 0",
                     lat, sum3, err3, err_cnt3);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; tr_en = 1'b0; fi_en = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; tr_en2 = 1'b0; fi_en2 = 1'b0; out_ready2 = 1'b1;
        in_valid3 = 1'b0; a3 = '0; b3 = '0; tr_en3 = 1'b0; fi_en3 = 1'b0; out_ready3 = 1'b1;
        test_reset();
        test_basic();
        test_tr();
        test_fault();
        test_backpressure();
        test_reset_mid();
        test_err_sat();
        test_single_slice();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
